// File: rtl/fog_demod_pkg.sv
// Shared types and helpers for the square-wave demodulator.
// Limits and sign extension are width-generic so callers pick ACC_W.
package fog_demod_pkg;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    SKIP      = 2'd1,
    ACC       = 2'd2
  } state_e;

  localparam int ADC_W_DEF = 14;
  localparam int ACC_W_DEF = 32;

  function automatic logic [63:0] acc_max64(input int w);
    return (64'h1 << (w - 1)) - 64'h1;
  endfunction

  function automatic logic [63:0] acc_min64(input int w);
    return ~acc_max64(w);
  endfunction

  function automatic logic [63:0] sext64(
    input logic [63:0] v,
    input int          w
  );
    logic [63:0] m;
    m = ~64'h0 << w;
    if ((v & (64'h1 << (w - 1))) != 64'h0)
      return v | m;
    return v & ~m;
  endfunction

endpackage

// File: rtl/square_demod_ut_sat_accum.sv
// Saturating signed accumulator with clear, enable and sticky
// saturation flag; clear wins over enable.
module sat_accum
  import fog_demod_pkg::*;
#(
  parameter int ADC_W = ADC_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [ADC_W-1:0] din_i,
  output logic [ACC_W-1:0] acc_o,
  output logic             sat_o
);

  localparam logic [ACC_W-1:0] ACC_MAX =
    ACC_W'(acc_max64(ACC_W));
  localparam logic [ACC_W-1:0] ACC_MIN =
    ACC_W'(acc_min64(ACC_W));

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;
  logic [ACC_W:0]   din_w, sum_w;
  logic             ovf;

  // One guard bit: overflow shows as the top two bits disagreeing.
  assign din_w = (ACC_W+1)'(sext64(64'(din_i), ADC_W));
  assign sum_w = {acc_q[ACC_W-1], acc_q} + din_w;
  assign ovf   = sum_w[ACC_W] ^ sum_w[ACC_W-1];

  always_comb begin
    acc_d = acc_q;
    sat_d = sat_q;
    if (clr_i) begin
      acc_d = '0;
      sat_d = 1'b0;
    end else if (en_i) begin
      if (ovf) begin
        acc_d = sum_w[ACC_W] ? ACC_MIN : ACC_MAX;
        sat_d = 1'b1;
      end else begin
        acc_d = sum_w[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end

  assign acc_o = acc_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/square_demod_ut.sv
// Square-wave demodulator: per-half sums after a settling window,
// error sum_H - sum_L strobed once per completed H/L pair.
module square_demod_ut
  import fog_demod_pkg::*;
#(
  parameter int ADC_W = ADC_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic signed [ADC_W-1:0] i_adc,
  input  logic                    i_status,
  input  logic                    i_stepTrig,
  input  logic        [31:0]      i_skip_cnt,
  output logic signed [ACC_W-1:0] o_sum_H,
  output logic signed [ACC_W-1:0] o_sum_L,
  output logic signed [ACC_W:0]   o_err,
  output logic                    o_err_vld,
  output logic                    o_sat
);

  state_e           state_q, state_d;
  logic [31:0]      n_q, n_d, n_inc;
  logic [31:0]      skip_q, skip_d;
  logic             have_h_q, have_h_d;
  logic             pend_q, pend_d;
  logic [ACC_W-1:0] sum_h_q, sum_h_d;
  logic [ACC_W-1:0] sum_l_q, sum_l_d;
  logic             sat_h_q, sat_h_d;
  logic             sat_l_q, sat_l_d;
  logic [ACC_W:0]   err_q, err_d;
  logic             sat_q, sat_d;
  logic             vld_q, vld_d;
  logic [ACC_W-1:0] acc;
  logic             acc_sat;
  logic             acc_clr, acc_en;

  sat_accum #(
    .ADC_W(ADC_W),
    .ACC_W(ACC_W)
  ) u_acc (
    .clk_i (i_clk),
    .rst_ni(i_rst_n),
    .clr_i (acc_clr),
    .en_i  (acc_en),
    .din_i (i_adc),
    .acc_o (acc),
    .sat_o (acc_sat)
  );

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    skip_d   = skip_q;
    have_h_d = have_h_q;
    pend_d   = 1'b0;
    sum_h_d  = sum_h_q;
    sum_l_d  = sum_l_q;
    sat_h_d  = sat_h_q;
    sat_l_d  = sat_l_q;
    err_d    = err_q;
    sat_d    = sat_q;
    vld_d    = 1'b0;
    acc_clr  = 1'b0;
    acc_en   = 1'b0;
    n_inc    = (n_q == '1) ? n_q : n_q + 32'd1;

    if (pend_q) begin
      err_d = (ACC_W+1)'(sext64(64'(sum_h_q), ACC_W)
                       - sext64(64'(sum_l_q), ACC_W));
      sat_d = sat_h_q | sat_l_q;
      vld_d = 1'b1;
    end

    // The trigger cycle's own sample never enters either half.
    if (i_stepTrig) begin
      if (state_q != WAIT_SYNC) begin
        if (i_status) begin
          sum_h_d  = acc;
          sat_h_d  = acc_sat;
          have_h_d = 1'b1;
        end else begin
          sum_l_d = acc;
          sat_l_d = acc_sat;
          pend_d  = have_h_q;
        end
      end
      acc_clr = 1'b1;
      n_d     = '0;
      skip_d  = i_skip_cnt;
      state_d = (i_skip_cnt == '0) ? ACC : SKIP;
    end else begin
      unique case (state_q)
        WAIT_SYNC: acc_clr = 1'b1;
        SKIP: begin
          n_d = n_inc;
          if (n_inc >= skip_q) state_d = ACC;
        end
        ACC: begin
          n_d    = n_inc;
          acc_en = 1'b1;
        end
        default: state_d = WAIT_SYNC;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= WAIT_SYNC;
      n_q      <= '0;
      skip_q   <= '0;
      have_h_q <= 1'b0;
      pend_q   <= 1'b0;
      sum_h_q  <= '0;
      sum_l_q  <= '0;
      sat_h_q  <= 1'b0;
      sat_l_q  <= 1'b0;
      err_q    <= '0;
      sat_q    <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      skip_q   <= skip_d;
      have_h_q <= have_h_d;
      pend_q   <= pend_d;
      sum_h_q  <= sum_h_d;
      sum_l_q  <= sum_l_d;
      sat_h_q  <= sat_h_d;
      sat_l_q  <= sat_l_d;
      err_q    <= err_d;
      sat_q    <= sat_d;
      vld_q    <= vld_d;
    end
  end

  assign o_sum_H   = sum_h_q;
  assign o_sum_L   = sum_l_q;
  assign o_err     = err_q;
  assign o_err_vld = vld_q;
  assign o_sat     = sat_q;

endmodule

// File: tb/tb_square_demod_ut.sv
// Bench for square_demod_ut: 32- and 16-bit accumulator instances
// share stimulus and are checked against a sample-list model.
module tb_square_demod_ut;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [13:0] adc;
  logic               status, trig;
  logic        [31:0] skip_in;

  logic signed [31:0] sh32, sl32;
  logic signed [32:0] e32;
  logic               v32, s32;
  logic signed [15:0] sh16, sl16;
  logic signed [16:0] e16;
  logic               v16, s16;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  square_demod_ut dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_adc(adc),
    .i_status(status), .i_stepTrig(trig),
    .i_skip_cnt(skip_in),
    .o_sum_H(sh32), .o_sum_L(sl32), .o_err(e32),
    .o_err_vld(v32), .o_sat(s32)
  );

  square_demod_ut #(.ACC_W(16)) dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_adc(adc),
    .i_status(status), .i_stepTrig(trig),
    .i_skip_cnt(skip_in),
    .o_sum_H(sh16), .o_sum_L(sl16), .o_err(e16),
    .o_err_vld(v16), .o_sat(s16)
  );

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: samples of the current half kept as a list, summed at close.
  int     wid[2] = '{32, 16};
  bit     synced, have_h, pend;
  int     m_skip;
  longint q[$];
  longint m_sh[2], m_sl[2], m_err[2], p_err[2];
  bit     m_shs[2], m_sls[2], m_sat[2], m_vld[2], p_sat[2];

  task automatic half_sum(input int w, output longint s,
                          output bit f);
    longint hi, lo;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -hi - 1;
    s = 0;
    f = 0;
    for (int i = m_skip; i < q.size(); i++) begin
      s += q[i];
      if (s > hi) begin s = hi; f = 1; end
      else if (s < lo) begin s = lo; f = 1; end
    end
  endtask

  task automatic model_step();
    longint s;
    bit     f;
    if (!rst_n) begin
      synced = 0; have_h = 0; pend = 0; m_skip = 0;
      q.delete();
      for (int j = 0; j < 2; j++) begin
        m_sh[j] = 0; m_sl[j] = 0; m_err[j] = 0;
        m_shs[j] = 0; m_sls[j] = 0;
        m_sat[j] = 0; m_vld[j] = 0;
      end
      return;
    end
    for (int j = 0; j < 2; j++) begin
      m_vld[j] = pend;
      if (pend) begin
        m_err[j] = p_err[j];
        m_sat[j] = p_sat[j];
      end
    end
    pend = 0;
    if (trig) begin
      if (synced) begin
        for (int j = 0; j < 2; j++) begin
          half_sum(wid[j], s, f);
          if (status) begin
            m_sh[j] = s; m_shs[j] = f;
          end else begin
            m_sl[j] = s; m_sls[j] = f;
            if (have_h) begin
              pend = 1;
              p_err[j] = m_sh[j] - m_sl[j];
              p_sat[j] = m_shs[j] | m_sls[j];
            end
          end
        end
        if (status) have_h = 1;
      end
      synced = 1;
      m_skip = int'(skip_in);
      q.delete();
    end else if (synced) begin
      q.push_back(longint'(adc));
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    chk("sum_H32", longint'(sh32), m_sh[0]);
    chk("sum_L32", longint'(sl32), m_sl[0]);
    chk("err32", longint'(e32), m_err[0]);
    chk("vld32", longint'(v32), longint'(m_vld[0]));
    chk("sat32", longint'(s32), longint'(m_sat[0]));
    chk("sum_H16", longint'(sh16), m_sh[1]);
    chk("sum_L16", longint'(sl16), m_sl[1]);
    chk("err16", longint'(e16), m_err[1]);
    chk("vld16", longint'(v16), longint'(m_vld[1]));
    chk("sat16", longint'(s16), longint'(m_sat[1]));
  end

  int cur_skip = 0;

  function automatic longint rnd();
    return longint'($urandom_range(16383, 0)) - 8192;
  endfunction

  task automatic cyc(bit t, bit st, longint a, int sk);
    @(negedge clk);
    trig    = t;
    status  = st;
    adc     = 14'(a);
    skip_in = sk;
  endtask

  // len samples, then the closing trigger; nxt is the next half's skip
  // and already shows on i_skip_cnt for the latter part of this half.
  task automatic half(bit st, int len, int mode, longint val,
                      int nxt);
    longint a;
    for (int i = 0; i < len; i++) begin
      case (mode)
        0:       a = val;
        1:       a = i;
        default: a = rnd();
      endcase
      cyc(0, st, a, (i < len / 2) ? cur_skip : nxt);
    end
    cyc(1, st, rnd(), nxt);
    cur_skip = nxt;
  endtask

  task automatic pin_zero(string tag);
    chk({tag, "_sum_H"}, longint'(sh32), 0);
    chk({tag, "_sum_L"}, longint'(sl32), 0);
    chk({tag, "_err"}, longint'(e32), 0);
    chk({tag, "_vld"}, longint'(v32), 0);
    chk({tag, "_sat"}, longint'(s32), 0);
    chk({tag, "_err16"}, longint'(e16), 0);
    chk({tag, "_sum_H16"}, longint'(sh16), 0);
  endtask

  bit last_st;

  initial begin
    rst_n = 0; trig = 0; status = 0; adc = 0; skip_in = 0;
    repeat (3) @(negedge clk);
    pin_zero("reset");
    rst_n = 1;

    // Sync and basic pair
    cur_skip = 2;
    repeat (5) cyc(0, 1, 100, 2);
    cyc(1, 0, 0, 2);
    half(0, 8, 0, -100, 2);
    half(1, 8, 0, 100, 2);
    half(0, 8, 0, -100, 2);
    half(1, 8, 0, 100, 0);
    chk("t1_sum_H", longint'(sh32), 600);
    chk("t1_sum_L", longint'(sl32), -600);
    chk("t1_err", longint'(e32), 1200);
    chk("t1_err16", longint'(e16), 1200);

    // Skip boundary with ramp samples
    half(0, 8, 1, 0, 8);
    half(1, 8, 1, 0, 10);
    chk("t2_skip0", longint'(sl32), 28);
    half(0, 8, 1, 0, 2);
    chk("t2_skip8", longint'(sh32), 0);
    half(1, 8, 1, 0, 4);
    chk("t2_skip10", longint'(sl32), 0);
    half(0, 8, 1, 0, 0);
    chk("t2_skip_mid", longint'(sh32), 27);
    half(1, 8, 0, 8191, 0);
    chk("t2_skip4", longint'(sl32), 22);
    chk("t2_err", longint'(e32), 5);

    // Saturation in the 16-bit instance
    half(0, 8, 0, 0, 0);
    chk("t3_clamp16", longint'(sh16), 32767);
    chk("t3_nosat32", longint'(sh32), 65528);
    half(1, 8, 0, 7, 0);
    chk("t3_sat16", longint'(s16), 1);
    chk("t3_err16", longint'(e16), 32767);
    chk("t3_sat32", longint'(s32), 0);
    half(0, 8, 0, -3, 0);
    half(1, 8, 0, 8191, 0);
    chk("t3_clean16", longint'(s16), 0);
    chk("t3_cerr16", longint'(e16), 80);

    // Extreme difference
    half(0, 8, 0, -8192, 0);
    half(1, 3, 0, 1, 0);
    chk("t6_err16", longint'(e16), 65535);
    chk("t6_sat16", longint'(s16), 1);
    chk("t6_err32", longint'(e32), 131064);

    // Zero-length halves
    half(0, 0, 0, 0, 0);
    half(1, 0, 0, 0, 0);
    half(0, 4, 0, 2, 0);
    chk("t4_sum_L", longint'(sl32), 0);
    chk("t4_sum_H", longint'(sh32), 0);
    chk("t4_err", longint'(e32), 3);

    // Reset in the middle of an accumulating H half
    repeat (5) cyc(0, 1, 50, 0);
    @(negedge clk);
    rst_n = 0;
    #1;
    pin_zero("t5_rst");
    @(negedge clk);
    rst_n = 1;
    repeat (3) cyc(0, 1, 50, 0);
    cyc(1, 1, 0, 0);
    cur_skip = 0;
    half(1, 8, 0, 9, 0);
    half(0, 8, 0, -1, 0);
    half(1, 2, 0, 0, 0);
    chk("t5_err", longint'(e32), 80);

    // Randomized halves
    last_st = 1;
    for (int k = 0; k < 60; k++) begin
      bit st;
      int nxt;
      st  = ($urandom_range(7, 0) == 0) ? last_st : !last_st;
      nxt = ($urandom_range(3, 0) == 0) ? 0
                                        : int'($urandom_range(14, 0));
      half(st, int'($urandom_range(12, 0)), 2, 0, nxt);
      last_st = st;
    end

    repeat (4) cyc(0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
